// File: rtl/ising_sweep_scheduler.sv
// Ising spin-update sequencer: per row READ -> MULT -> UPDATE (3 cycles), Gauss-Seidel order, done pulse after last sweep.
// No backpressure: weight memory answers the cycle after w_rd_en, multiplier is combinational; abort returns to IDLE.
module ising_sweep_scheduler #(
  parameter int word_size  = 4,
  parameter int array_size = 51,
  parameter int SWEEP_W    = 8,
  localparam int N     = (array_size - 5) / 2,
  localparam int AW    = (N > 1) ? $clog2(N) : 1,
  localparam int SUM_W = word_size + AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SWEEP_W-1:0]     num_sweeps,
  input  logic                   spin_load_en,
  input  logic [N-1:0]           spin_load_data,
  output logic                   w_rd_en,
  output logic [AW-1:0]          w_addr,
  input  logic [N*word_size-1:0] w_rdata,
  output logic [N*word_size-1:0] mult_weight,
  output logic [N-1:0]           mult_spin,
  input  logic [N*word_size-1:0] mult_product,
  output logic [N-1:0]           spin_out,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_MULT, S_UPDATE, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            row_q;
  logic [SWEEP_W-1:0]       sweep_cnt_q;
  logic [SWEEP_W-1:0]       sweeps_q;
  logic [N-1:0]             spin_q;
  logic signed [SUM_W-1:0]  field_q;
  logic signed [SUM_W-1:0]  field_sum;
  logic                     last_row;
  logic                     last_sweep;

  assign last_row   = (row_q == AW'(N - 1));
  assign last_sweep = (({1'b0, sweep_cnt_q} + (SWEEP_W+1)'(1)) == {1'b0, sweeps_q});

  // Local field: sign-extended products of every column except the row being updated
  always_comb begin
    field_sum = '0;
    for (int j = 0; j < N; j++) begin
      if (AW'(j) != row_q)
        field_sum = field_sum + SUM_W'(signed'(mult_product[j*word_size +: word_size]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    w_rd_en = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = (num_sweeps == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        w_rd_en = 1'b1;
        state_d = S_MULT;
      end
      S_MULT:   state_d = S_UPDATE;
      S_UPDATE: state_d = (last_row && last_sweep) ? S_DONE : S_READ;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      sweep_cnt_q <= '0;
      sweeps_q    <= '0;
      spin_q      <= '0;
      field_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (spin_load_en) spin_q <= spin_load_data;
          if (start) begin
            sweeps_q    <= num_sweeps;
            row_q       <= '0;
            sweep_cnt_q <= '0;
          end
        end
        S_MULT: field_q <= field_sum;
        S_UPDATE: begin
          // An aborted UPDATE leaves the spin and row untouched
          if (!abort) begin
            if (field_q != '0) spin_q[row_q] <= ~field_q[SUM_W-1];
            if (last_row) begin
              row_q       <= '0;
              sweep_cnt_q <= sweep_cnt_q + 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_addr      = row_q;
  assign mult_weight = w_rdata;
  assign mult_spin   = spin_q;
  assign spin_out    = spin_q;

endmodule

// File: tb/tb_ising_sweep_scheduler.sv
// Directed bench for ising_sweep_scheduler: table of whole runs plus hand sequences for reset and abort.
module tb_ising_sweep_scheduler;
  localparam int WS = 4;
  localparam int N  = 23;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort, spin_load_en;
  logic [7:0]        num_sweeps;
  logic [N-1:0]      spin_load_data;
  logic              w_rd_en;
  logic [AW-1:0]     w_addr;
  logic [N*WS-1:0]   w_rdata;
  logic [N*WS-1:0]   mult_weight;
  logic [N-1:0]      mult_spin;
  logic [N*WS-1:0]   mult_product;
  logic [N-1:0]      spin_out;
  logic              busy, done;
  logic [WS-1:0]     wword;

  int errors = 0;
  int checks = 0;

  ising_sweep_scheduler #(.word_size(WS), .array_size(51), .SWEEP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_sweeps(num_sweeps), .spin_load_en(spin_load_en),
    .spin_load_data(spin_load_data), .w_rd_en(w_rd_en), .w_addr(w_addr),
    .w_rdata(w_rdata), .mult_weight(mult_weight), .mult_spin(mult_spin),
    .mult_product(mult_product), .spin_out(spin_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Weight memory: every row holds wword in every column, one-cycle read latency
  always @(posedge clk) begin
    if (w_rd_en) w_rdata <= {N{wword}};
  end

  function automatic logic [WS-1:0] mulw(input logic [WS-1:0] w, input logic s);
    int v;
    v = w[0] ? int'(w[WS-1:1]) : -int'(w[WS-1:1]);
    if (!s) v = -v;
    return v[WS-1:0];
  endfunction

  always_comb begin
    mult_product = '0;
    for (int j = 0; j < N; j++)
      mult_product[j*WS +: WS] = mulw(mult_weight[j*WS +: WS], mult_spin[j]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [7:0] s, input logic [N-1:0] d, input logic [WS-1:0] w);
    wword          = w;
    spin_load_en   = 1'b1;
    spin_load_data = d;
    num_sweeps     = s;
    start          = 1'b1;
    step();
    start        = 1'b0;
    spin_load_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0]    sweeps;
    logic [N-1:0]  load;
    logic [WS-1:0] w;
    int            done_cyc;
    logic [N-1:0]  fin;
    int            field0;
    bit            uniform;
    int            rds;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // ferromagnetic hold, flip-and-propagate, zero-field tie, zero sweeps with load, antiferro partial flip
    vecs[0] = '{8'd1, 23'h000000, 4'b0011,  70, 23'h000000, -22, 1'b1, 23};
    vecs[1] = '{8'd1, 23'h7FFFFE, 4'b0011,  70, 23'h7FFFFF,  22, 1'b1, 23};
    vecs[2] = '{8'd3, 23'h2AAAAA, 4'b0000, 208, 23'h2AAAAA,   0, 1'b1, 69};
    vecs[3] = '{8'd0, 23'h000F0F, 4'b0011,   1, 23'h000F0F,   0, 1'b0,  0};
    vecs[4] = '{8'd1, 23'h000000, 4'b0010,  70, 23'h0007FF,  22, 1'b0, 23};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; spin_load_en = 1'b0;
    num_sweeps = '0; spin_load_data = '0; wword = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_rd_en", 64'(w_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_w_addr", 64'(w_addr), 64'd0);
    chk("rst_spin_out", 64'(spin_out), 64'd0);
    chk("rst_mult_spin", 64'(mult_spin), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      int cyc, done_cyc, rd_cnt, b2b, addr_bad, busy_bad, field_bad, first_fq, fq;
      bit got, p1, p2, have_first;
      cyc = 1; done_cyc = -1; rd_cnt = 0; b2b = 0; addr_bad = 0; busy_bad = 0;
      field_bad = 0; first_fq = 0; got = 0; p1 = 0; p2 = 0; have_first = 0;
      begin_run(vecs[v].sweeps, vecs[v].load, vecs[v].w);
      while (cyc <= 400 && !got) begin
        if (!busy) busy_bad++;
        if (p2) begin
          fq = int'(dut.field_q);
          if (!have_first) begin first_fq = fq; have_first = 1; end
          if (vecs[v].uniform && fq != vecs[v].field0) field_bad++;
        end
        if (w_rd_en) begin
          if (p1) b2b++;
          if (int'(w_addr) != rd_cnt % N) addr_bad++;
          rd_cnt++;
        end
        if (done) begin got = 1; done_cyc = cyc; end
        p2 = p1; p1 = w_rd_en;
        if (!got) begin step(); cyc++; end
      end
      chk($sformatf("v%0d_done_seen", v), 64'(got), 64'd1);
      chk($sformatf("v%0d_done_cycle", v), 64'(done_cyc), 64'(vecs[v].done_cyc));
      chk($sformatf("v%0d_reads", v), 64'(rd_cnt), 64'(vecs[v].rds));
      chk($sformatf("v%0d_b2b_reads", v), 64'(b2b), 64'd0);
      chk($sformatf("v%0d_addr_seq", v), 64'(addr_bad), 64'd0);
      chk($sformatf("v%0d_busy_low", v), 64'(busy_bad), 64'd0);
      if (vecs[v].rds > 0)
        chk($sformatf("v%0d_field_row0", v), 64'(first_fq), 64'(vecs[v].field0));
      if (vecs[v].uniform)
        chk($sformatf("v%0d_field_rows", v), 64'(field_bad), 64'd0);
      step();
      chk($sformatf("v%0d_done_single", v), 64'(done), 64'd0);
      chk($sformatf("v%0d_busy_after", v), 64'(busy), 64'd0);
      chk($sformatf("v%0d_spin_out", v), 64'(spin_out), 64'(vecs[v].fin));
    end

    // Abort at READ of row 10 with busy-time start/load pulses in between
    begin_run(8'd1, 23'h000000, 4'b0010);
    repeat (4) step();
    start = 1'b1; spin_load_en = 1'b1; spin_load_data = '1; num_sweeps = 8'd0;
    step();
    start = 1'b0; spin_load_en = 1'b0;
    repeat (25) step();
    chk("abort_pre_rd_en", 64'(w_rd_en), 64'd1);
    chk("abort_pre_addr", 64'(w_addr), 64'd10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_spin", 64'(spin_out), 64'h0003FF);
    step();
    chk("abort_done_later", 64'(done), 64'd0);
    chk("abort_spin_later", 64'(spin_out), 64'h0003FF);

    // Asynchronous reset in MULT of row 5, sweep 0
    begin_run(8'd1, 23'h155555, 4'b0011);
    repeat (15) step();
    chk("mid_rd_en_row5", 64'(w_rd_en), 64'd1);
    chk("mid_addr_row5", 64'(w_addr), 64'd5);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_rd_en", 64'(w_rd_en), 64'd0);
    chk("mid_rst_addr", 64'(w_addr), 64'd0);
    chk("mid_rst_spin", 64'(spin_out), 64'd0);
    chk("mid_rst_mult_spin", 64'(mult_spin), 64'd0);
    chk("mid_rst_field", 64'(int'(dut.field_q)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int done_seen;
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (done || busy) done_seen++;
      end
      chk("mid_rst_quiet", 64'(done_seen), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ising_sweep_scheduler.md
# ising_sweep_scheduler

Sequences the spin-update loop around `vector_multiplier` for one Ising array. For each sweep it reads weight rows one at a time and drives each row and the current spin vector into the multiplier. It then sums the signed products into a local field and updates that row's spin from the field's sign. It sits between the weight row memory and the spin register consumer, and owns the spin state.

## Interface
- `word_size`, 4: width of one weight/product word; must be ≥3.
- `array_size`, 51: array geometry; spin count N = (array_size-5)/2 (23 at default).
- `SWEEP_W`, 8: width of the sweep-count input.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin annealing run; sampled in IDLE only.
- `abort`  in  1  synchronous stop; returns to IDLE, no `done`.
- `num_sweeps`  in  SWEEP_W  sweeps per run, latched on accepted `start`.
- `spin_load_en`  in  1  load spin register; honoured in IDLE only.
- `spin_load_data`  in  N  initial spins (1 = +1, 0 = -1).
- `w_rd_en`  out  1  weight memory read strobe.
- `w_addr`  out  clog2(N)  weight row index.
- `w_rdata`  in  N*word_size  weight row, valid the cycle after `w_rd_en`. Word j = column j: bits [word_size-1:1] magnitude, bit [0] sign (1 positive).
- `mult_weight`  out  N*word_size  to multiplier `weight_vector`; equals `w_rdata`.
- `mult_spin`  out  N  to multiplier `spin_vector`; equals spin register.
- `mult_product`  in  N*word_size  from multiplier; two's-complement products.
- `spin_out`  out  N  current spin register.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at end of run.

## Operation
- Definitions: SUM_W = word_size + clog2(N); field = signed sum of all product words except column `row`. Products are sign-extended to SUM_W; no overflow is possible.
- States: IDLE, READ, MULT, UPDATE, DONE.
- IDLE
  - `spin_load_en` copies `spin_load_data` into the spin register.
  - `start` latches `num_sweeps`, clears `row` and `sweep_cnt`, then:
    - goes to DONE if `num_sweeps` = 0;
    - goes to READ otherwise.
  - If `start` and `spin_load_en` coincide, the load takes effect and the run begins with the loaded spins.
- READ: `w_rd_en`=1, `w_addr`=`row`; go to MULT.
- MULT: `w_rdata` is valid, the multiplier is combinational, and field is registered into `field_q`; go to UPDATE.
- UPDATE: set `spin[row]` from `field_q`:
  - 1 if `field_q` > 0;
  - 0 if `field_q` < 0;
  - unchanged if `field_q` = 0.
- UPDATE transitions:
  - If `row` < N-1: `row`++ and go to READ.
  - Otherwise set `row`=0 and `sweep_cnt`++. Go to DONE if `sweep_cnt`+1 = latched sweeps, else go to READ.
- DONE: `done`=1 for one cycle; go to IDLE.
- Updates are sequential (Gauss-Seidel): row r+1 sees the updated `spin[r]`.
- `abort` is high in any non-IDLE state: next state is IDLE. The spin register keeps its partial result, `done` is not pulsed, and `abort` has priority over all transitions.
- `start` and `spin_load_en` are ignored while `busy`.

## Timing
- Reset values:
  - state IDLE; `w_rd_en`, `busy`, `done` = 0; `w_addr`=0;
  - spin register = 0, so `spin_out`=0 and `mult_spin`=0;
  - `field_q`=0, `row`=0, `sweep_cnt`=0.
- Reset asserted mid-run clears everything immediately (asynchronously). No `done` is pulsed.
- `start` is sampled at edge 0, giving READ in cycle 1. Each row takes 3 cycles (READ, MULT, UPDATE).
- `done` is high in cycle 3·N·S + 1 after the `start` edge, for S = `num_sweeps`.
- With S=0, `done` is high in cycle 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- A spin update is visible on `spin_out` the cycle after UPDATE.
- `w_rd_en` is a single-cycle pulse per row. There is no back-to-back read.

## Test plan
- Reset mid-run:
  - Stimulus: assert `rst_n`=0 in MULT of row 5, sweep 0.
  - Required: all outputs immediately return to reset values; `spin_out`=0; no `done` pulse.
- Ferromagnetic hold:
  - Stimulus: all weights 4'b0011 (+1), load all spins 0, `num_sweeps`=1.
  - Required: every `field_q` = -22; `spin_out` stays 0; `done` in cycle 70.
- Flip and propagate:
  - Stimulus: same weights, load `spin_load_data` = all ones except bit 0, `num_sweeps`=1.
  - Required: row 0 `field_q`=+22 and `spin[0]`→1; final `spin_out` is all ones.
- Zero-field tie:
  - Stimulus: all weights 4'b0000, load spins 0x2AAAAA, `num_sweeps`=3.
  - Required: every `field_q` = 0; `spin_out` stays 0x2AAAAA; `done` in cycle 208.
- Abort and ignored inputs:
  - Stimulus: abort during sweep 0, row 10; also pulse `start` and `spin_load_en` while busy.
  - Required: return to IDLE next cycle with no `done`; rows 0–9 keep their updates; the busy-time pulses have no effect.
- Zero sweeps plus simultaneous load:
  - Stimulus: `start` with `num_sweeps`=0 and `spin_load_en`=1, data 0x000F0F.
  - Required: no `w_rd_en`; `done` in cycle 1; `spin_out`=0x000F0F.
